// File: rtl/channel_mux_if.sv
// Channel bundle bus between a port-bundle source and the channel mux:
// per-port flit bundles plus one-hot select in, registered bundle and select-error flag out.
interface channel_mux_if #(
  parameter int Numports = 4,
  parameter int Flits    = 8,
  parameter int FlitW    = 64
);
  logic [Numports-1:0][Flits-1:0][FlitW-1:0] D;
  logic [Numports-1:0]                       SEL;
  logic [Flits-1:0][FlitW-1:0]               Q;
  logic                                      SEL_ERR;

  modport master (output D, output SEL, input Q, input SEL_ERR);
  modport slave  (input D, input SEL, output Q, output SEL_ERR);
endinterface

// File: rtl/channel_mux.sv
// Registered one-hot channel mux: forwards D[p] for the selected port, lowest index wins on multi-hot.
// Latency 1 cycle, full throughput; no backpressure (select may change every cycle, no handshake).
module channel_mux #(
  parameter int Numports = 4,
  parameter int Flits    = 8,
  parameter int FlitW    = 64
) (
  input logic         CLK,
  input logic         RST,
  channel_mux_if.slave bus
);

  typedef logic [Flits-1:0][FlitW-1:0] bundle_t;

  logic [Numports-1:0] grant;
  logic                multi_hot;
  bundle_t             mux_dat;
  bundle_t             q_reg;
  logic                err_reg;

  // Isolate the lowest set bit; any remaining bit means the select was multi-hot.
  always_comb begin
    grant     = bus.SEL & (~bus.SEL + Numports'(1));
    multi_hot = |(bus.SEL & ~grant);
  end

  always_comb begin
    mux_dat = '0;
    for (int p = 0; p < Numports; p++) begin
      mux_dat = mux_dat | (bus.D[p] & {(Flits * FlitW){grant[p]}});
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg   <= '0;
      err_reg <= 1'b0;
    end else begin
      q_reg   <= mux_dat;
      err_reg <= multi_hot;
    end
  end

  assign bus.Q       = q_reg;
  assign bus.SEL_ERR = err_reg;

endmodule

// File: tb/tb_channel_mux.sv
// Directed bench for channel_mux: reset, select, port walk, idle, multi-hot and mid-stream reset.
module tb_channel_mux;

  localparam int NP = 4;
  localparam int NF = 8;
  localparam int FW = 64;

  typedef logic [NF-1:0][FW-1:0] bundle_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  channel_mux_if #(.Numports(NP), .Flits(NF), .FlitW(FW)) bus ();

  channel_mux #(.Numports(NP), .Flits(NF), .FlitW(FW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bundle_t make_walk(input int p);
    bundle_t b;
    for (int f = 0; f < NF; f++) b[f] = {8'(p + 1), 48'h0, 8'(f)};
    return b;
  endfunction

  function automatic bundle_t make_basic();
    bundle_t b;
    for (int f = 0; f < 3; f++) b[f] = 64'h0200_0000_0000_0000;
    b[3] = 64'h0100_0000_0000_0001;
    for (int f = 4; f < 7; f++) b[f] = 64'h0100_0000_0000_0000;
    b[7] = 64'h0000_0000_0000_000A;
    return b;
  endfunction

  bundle_t basic;
  bundle_t fresh;

  initial begin
    rst     = 1'b1;
    bus.D   = '1;
    bus.SEL = 4'b0001;

    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("reset_q", bus.Q, '0);
      check_eq("reset_err", 512'(bus.SEL_ERR), 512'(0));
    end

    // Basic select of port 0, applied together with reset release.
    basic    = make_basic();
    rst      = 1'b0;
    bus.D[0] = basic;
    bus.D[1] = basic;
    bus.D[2] = '0;
    bus.D[3] = '0;
    bus.SEL  = 4'b0001;
    tick();
    check_eq("basic_q", bus.Q, basic);
    check_eq("basic_err", 512'(bus.SEL_ERR), 512'(0));

    // Port walk, one port per cycle with no gaps.
    for (int p = 0; p < NP; p++) bus.D[p] = make_walk(p);
    for (int p = 0; p < NP; p++) begin
      bus.SEL = 4'(1 << p);
      tick();
      check_eq($sformatf("walk_q%0d", p), bus.Q, make_walk(p));
      check_eq($sformatf("walk_err%0d", p), 512'(bus.SEL_ERR), 512'(0));
    end

    bus.SEL = 4'b0000;
    tick();
    check_eq("idle_q", bus.Q, '0);
    check_eq("idle_err", 512'(bus.SEL_ERR), 512'(0));

    bus.SEL = 4'b0110;
    tick();
    check_eq("multi_q", bus.Q, make_walk(1));
    check_eq("multi_err", 512'(bus.SEL_ERR), 512'(1));

    bus.SEL = 4'b0100;
    tick();
    check_eq("after_multi_q", bus.Q, make_walk(2));
    check_eq("after_multi_err", 512'(bus.SEL_ERR), 512'(0));

    bus.SEL = 4'b1111;
    tick();
    check_eq("all_hot_q", bus.Q, make_walk(0));
    check_eq("all_hot_err", 512'(bus.SEL_ERR), 512'(1));

    // New data on a newly selected port at the same edge.
    fresh    = make_walk(3) ^ {NF{64'hFF00_0000_DEAD_BEEF}};
    bus.D[3] = fresh;
    bus.SEL  = 4'b1000;
    tick();
    check_eq("swap_q", bus.Q, fresh);

    bus.SEL = 4'b0010;
    tick();
    check_eq("stream_q", bus.Q, make_walk(1));

    rst = 1'b1;
    tick();
    check_eq("midrst_q", bus.Q, '0);
    check_eq("midrst_err", 512'(bus.SEL_ERR), 512'(0));

    rst = 1'b0;
    tick();
    check_eq("post_rst_q", bus.Q, make_walk(1));
    check_eq("post_rst_err", 512'(bus.SEL_ERR), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
